// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: sample width and window FSM states.
package alu_pkg;

    localparam int ALU_DATA_W = 8;

    typedef enum logic {ACC, DONE} win_state_t;

endpackage

// File: rtl/alu_result_window_if.sv
// Handshake bundle between the ALU result stream, the window block and its consumer.
interface alu_result_window_if
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int WINDOW = 4
);
    localparam int SUM_W = DATA_W + $clog2(WINDOW);

    logic              clear;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [DATA_W-1:0] out_min;
    logic [DATA_W-1:0] out_max;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_min, out_max
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_min, out_max
    );

endinterface

// File: rtl/alu_result_window_minmax_track.sv
// Running minimum/maximum of the samples accepted in the current window.
module minmax_track #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample,
    input  logic              clr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] acc_min,
    output logic [DATA_W-1:0] acc_max,
    output logic [DATA_W-1:0] min_nxt,
    output logic [DATA_W-1:0] max_nxt
);

    // Next values include the current sample so the top can capture the final totals.
    always_comb begin
        min_nxt = (data < acc_min) ? data : acc_min;
        max_nxt = (data > acc_max) ? data : acc_max;
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            acc_min <= '1;
            acc_max <= '0;
        end else if (sample) begin
            acc_min <= min_nxt;
            acc_max <= max_nxt;
        end
    end

endmodule

// File: rtl/alu_result_window.sv
// Collects WINDOW accepted ALU results and presents their sum, minimum and maximum.
module alu_result_window
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int WINDOW = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_result_window_if.slave bus
);

    localparam int SUM_W = DATA_W + $clog2(WINDOW);
    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

    win_state_t        state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [SUM_W-1:0]  acc_sum;
    logic [SUM_W-1:0]  sum_nxt;
    logic [DATA_W-1:0] acc_min, acc_max, min_nxt, max_nxt;
    logic              accept;
    logic              last;

    always_comb begin
        bus.in_ready  = (state == ACC) && rst && !bus.clear;
        bus.out_valid = (state == DONE);
        accept        = bus.in_valid && bus.in_ready;
        last          = accept && (cnt == LAST_CNT);
        sum_nxt       = acc_sum + SUM_W'(bus.in_data);
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= ACC;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (bus.clear) begin
            state_n = ACC;
        end else begin
            case (state)
                ACC:  if (last)          state_n = DONE;
                DONE: if (bus.out_ready) state_n = ACC;
                default:                 state_n = ACC;
            endcase
        end
    end

    // The window's last sample re-initialises the accumulators in the same edge it is captured.
    always_ff @(posedge clk) begin
        if (!rst || bus.clear || last) begin
            cnt     <= '0;
            acc_sum <= '0;
        end else if (accept) begin
            cnt     <= cnt + CNT_W'(1);
            acc_sum <= sum_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.out_sum <= '0;
            bus.out_min <= '0;
            bus.out_max <= '0;
        end else if (last) begin
            bus.out_sum <= sum_nxt;
            bus.out_min <= min_nxt;
            bus.out_max <= max_nxt;
        end
    end

    minmax_track #(.DATA_W(DATA_W)) u_minmax (
        .clk     (clk),
        .rst     (rst),
        .sample  (accept),
        .clr     (bus.clear || last),
        .data    (bus.in_data),
        .acc_min (acc_min),
        .acc_max (acc_max),
        .min_nxt (min_nxt),
        .max_nxt (max_nxt)
    );

endmodule
